// File: rtl/sprite_engine_if.sv
// Register-write and sprite-memory read bus between the CPU/VGA bridge and the sprite engine.
// The bridge side (master) issues register writes and returns memory data; the engine (slave) issues reads.
interface sprite_engine_if #(
  parameter int REG_AW = 7,
  parameter int MEM_AW = 9
);
  logic              reg_wr;
  logic [REG_AW-1:0] reg_addr;
  logic [15:0]       reg_wdata;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_rdata;

  modport master (output reg_wr, reg_addr, reg_wdata, mem_rdata,
                  input  mem_rd, mem_addr);
  modport slave  (input  reg_wr, reg_addr, reg_wdata, mem_rdata,
                  output mem_rd, mem_addr);
endinterface

// File: rtl/sprite_engine.sv
// Multi-sprite line engine: per-line row prefetch into double buffers, fixed-priority
// compositing to 4:4:4 RGB, and sticky collision flags.
module sprite_engine #(
  parameter int          NUM_SPRITES = 5,
  parameter int          MEM_AW      = 9,
  parameter int          REG_AW      = 7,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  sprite_engine_if.slave         bus,
  input  logic                   linebegin_i,
  input  logic [10:0]            fetch_line_i,
  input  logic [11:0]            h_addr_i,
  input  logic                   on_screen_i,
  output logic [3:0]             vga_r_o,
  output logic [3:0]             vga_g_o,
  output logic [3:0]             vga_b_o,
  output logic [NUM_SPRITES-1:0] coll_flags_o,
  output logic                   fetch_busy_o,
  output logic                   fetch_overrun_o
);
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;

  logic [11:0]       x_q     [NUM_SPRITES];
  logic [10:0]       y_q     [NUM_SPRITES];
  logic [MEM_AW-1:0] base_q  [NUM_SPRITES];
  logic [11:0]       color_q [NUM_SPRITES];
  logic [1:0]        scale_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] en_q;

  logic [15:0] pend_q [NUM_SPRITES];
  logic [15:0] act_q  [NUM_SPRITES];

  state_t      state_q;
  logic [IW-1:0] idx_q;
  logic [10:0] line_q;
  logic        ovr_q;

  logic [11:0]            rgb_q, rgb_d;
  logic [NUM_SPRITES-1:0] coll_q, coll_d;

  logic clr_coll;
  logic unused_wdata;
  assign clr_coll     = bus.reg_wr && (bus.reg_addr == REG_AW'(4 * NUM_SPRITES));
  assign unused_wdata = bus.reg_wdata[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        base_q[i]  <= '0;
        color_q[i] <= '0;
        scale_q[i] <= '0;
      end
      en_q <= '0;
    end else if (bus.reg_wr) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (bus.reg_addr[REG_AW-1:2] == (REG_AW-2)'(i)) begin
          case (bus.reg_addr[1:0])
            2'd0: x_q[i]    <= bus.reg_wdata[11:0];
            2'd1: y_q[i]    <= bus.reg_wdata[10:0];
            2'd2: base_q[i] <= bus.reg_wdata[MEM_AW-1:0];
            default: begin
              color_q[i] <= bus.reg_wdata[15:4];
              scale_q[i] <= bus.reg_wdata[3:2];
              en_q[i]    <= bus.reg_wdata[0];
            end
          endcase
        end
      end
    end
  end

  // Column hit test: offset from X, scaled down to a bit column (bit 15 = leftmost pixel).
  logic [NUM_SPRITES-1:0] hit;
  logic [12:0] cdiff  [NUM_SPRITES];
  logic [11:0] cwidth [NUM_SPRITES];
  logic [3:0]  ccol   [NUM_SPRITES];
  logic [11:0] pix;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      cdiff[i]  = {1'b0, h_addr_i} - {1'b0, x_q[i]};
      cwidth[i] = 12'd16 << scale_q[i];
      ccol[i]   = 4'(cdiff[i][11:0] >> scale_q[i]);
      hit[i]    = en_q[i] && !cdiff[i][12] && (cdiff[i][11:0] < cwidth[i])
                  && act_q[i][4'd15 - ccol[i]];
    end
  end

  always_comb begin
    pix = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix = color_q[i];
    end
    rgb_d  = on_screen_i ? pix : 12'h000;
    coll_d = clr_coll ? '0 : coll_q;
    // A fresh overlap beats a same-cycle clear.
    if (on_screen_i && |(hit & (hit - NUM_SPRITES'(1)))) coll_d = coll_d | hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q  <= '0;
      coll_q <= '0;
    end else begin
      rgb_q  <= rgb_d;
      coll_q <= coll_d;
    end
  end

  logic [11:0] ddiff, dwidth;
  logic [3:0]  drow;
  logic        fetch_go, last;

  always_comb begin
    ddiff    = {1'b0, line_q} - {1'b0, y_q[idx_q]};
    dwidth   = 12'd16 << scale_q[idx_q];
    drow     = 4'(ddiff >> scale_q[idx_q]);
    fetch_go = (state_q == CHECK) && en_q[idx_q] && !ddiff[11] && (ddiff < dwidth);
    last     = (idx_q == IW'(NUM_SPRITES - 1));
  end

  // Read strobe is decoded from CHECK so the data lands exactly in the following WAIT cycle.
  assign bus.mem_rd   = fetch_go;
  assign bus.mem_addr = base_q[idx_q] + MEM_AW'(drow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else if (linebegin_i) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_q[i]  <= pend_q[i];
        pend_q[i] <= '0;
      end
      line_q  <= fetch_line_i;
      idx_q   <= '0;
      state_q <= CHECK;
      if (state_q != IDLE) ovr_q <= 1'b1;
    end else begin
      case (state_q)
        CHECK: begin
          if (fetch_go)  state_q <= WAIT;
          else if (last) state_q <= IDLE;
          else           idx_q   <= idx_q + IW'(1);
        end
        WAIT: begin
          pend_q[idx_q] <= bus.mem_rdata;
          if (last) state_q <= IDLE;
          else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= CHECK;
          end
        end
        default: ;
      endcase
    end
  end

  assign vga_r_o         = rgb_q[11:8];
  assign vga_g_o         = rgb_q[7:4];
  assign vga_b_o         = rgb_q[3:0];
  assign coll_flags_o    = coll_q;
  assign fetch_busy_o    = (state_q != IDLE);
  assign fetch_overrun_o = ovr_q;
endmodule

// File: tb/tb_sprite_engine.sv
// Randomised and directed bench for sprite_engine against a line-schedule reference model.
module tb_sprite_engine;
  localparam int          N   = 5;
  localparam int          MAW = 9;
  localparam int          RAW = 7;
  localparam logic [11:0] BG  = 12'h0A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_engine_if #(.REG_AW(RAW), .MEM_AW(MAW)) bus();

  logic         lb;
  logic [10:0]  fl;
  logic [11:0]  h;
  logic         on;
  logic [3:0]   vr, vg, vb;
  logic [N-1:0] coll;
  logic         busy, ovr;

  sprite_engine #(.NUM_SPRITES(N), .MEM_AW(MAW), .REG_AW(RAW), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .linebegin_i(lb), .fetch_line_i(fl), .h_addr_i(h), .on_screen_i(on),
    .vga_r_o(vr), .vga_g_o(vg), .vga_b_o(vb),
    .coll_flags_o(coll), .fetch_busy_o(busy), .fetch_overrun_o(ovr)
  );

  logic [15:0] mem [512];
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 16'($urandom);

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [11:0]  m_x [N];
  logic [10:0]  m_y [N];
  logic [8:0]   m_base [N];
  logic [15:0]  m_ctrl [N];
  logic [15:0]  m_act [N];
  logic [15:0]  m_pend [N];
  logic [11:0]  m_rgb;
  logic [N-1:0] m_coll;
  logic         m_ovr;
  // Fetch schedule for the current line: cycle k (1-based) after linebegin
  int           ft, flen;
  bit           s_rd [2*N+2];
  logic [8:0]   s_addr [2*N+2];
  int           s_st [2*N+2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_base[i] = '0; m_ctrl[i] = '0;
      m_act[i] = '0; m_pend[i] = '0;
    end
    for (int j = 0; j < 2*N+2; j++) begin
      s_rd[j] = 1'b0; s_addr[j] = '0; s_st[j] = -1;
    end
    m_rgb = '0; m_coll = '0; m_ovr = 1'b0; ft = 0; flen = 0;
  endtask

  function automatic bit m_hit(input int i, input int hh);
    int s, c;
    s = int'(m_ctrl[i][3:2]);
    c = hh - int'(m_x[i]);
    if (!m_ctrl[i][0] || c < 0 || c >= (16 << s)) return 1'b0;
    return m_act[i][15 - (c >> s)];
  endfunction

  task automatic build_sched(input int line);
    int k, s, d;
    for (int j = 0; j < 2*N+2; j++) begin
      s_rd[j] = 1'b0; s_addr[j] = '0; s_st[j] = -1;
    end
    k = 1;
    for (int i = 0; i < N; i++) begin
      s = int'(m_ctrl[i][3:2]);
      d = line - int'(m_y[i]);
      if (m_ctrl[i][0] && d >= 0 && d < (16 << s)) begin
        s_rd[k]   = 1'b1;
        s_addr[k] = 9'((int'(m_base[i]) + (d >> s)) % 512);
        s_st[k+1] = i;
        k += 2;
      end else k++;
    end
    flen = k - 1;
    ft   = 1;
  endtask

  task automatic model_step();
    logic [N-1:0] hits;
    int cnt, a;
    logic [11:0] col;
    bit found;
    if (rst) begin model_reset(); return; end
    hits = '0; cnt = 0; col = BG; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_hit(i, int'(h))) begin
        hits[i] = 1'b1; cnt++;
        if (!found) begin col = m_ctrl[i][15:4]; found = 1'b1; end
      end
    end
    m_rgb = on ? col : 12'h000;
    if (bus.reg_wr && int'(bus.reg_addr) == 4*N) m_coll = '0;
    if (on && cnt >= 2) m_coll = m_coll | hits;
    if (bus.reg_wr && int'(bus.reg_addr) < 4*N) begin
      a = int'(bus.reg_addr);
      case (a % 4)
        0: m_x[a/4]    = bus.reg_wdata[11:0];
        1: m_y[a/4]    = bus.reg_wdata[10:0];
        2: m_base[a/4] = bus.reg_wdata[8:0];
        default: m_ctrl[a/4] = bus.reg_wdata;
      endcase
    end
    if (lb) begin
      if (ft != 0) m_ovr = 1'b1;
      for (int i = 0; i < N; i++) begin m_act[i] = m_pend[i]; m_pend[i] = '0; end
      build_sched(int'(fl));
    end else if (ft != 0) begin
      if (s_st[ft] >= 0) m_pend[s_st[ft]] = mem[s_addr[ft-1]];
      ft = (ft == flen) ? 0 : ft + 1;
    end
  endtask

  task automatic compare();
    bit erd;
    erd = (ft != 0) && s_rd[ft];
    chk("fetch_busy", 32'(busy), 32'(ft != 0));
    chk("mem_rd", 32'(bus.mem_rd), 32'(erd));
    if (erd) chk("mem_addr", 32'(bus.mem_addr), 32'(s_addr[ft]));
    chk("rgb", 32'({vr, vg, vb}), 32'(m_rgb));
    chk("coll_flags", 32'(coll), 32'(m_coll));
    chk("fetch_overrun", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
    bus.reg_wr = 1'b0;
    lb = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ft != 0 && n < 100) begin cycle(); n++; end
    if (ft != 0) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wait_idle();
    bus.reg_wr = 1'b1; bus.reg_addr = 7'(a); bus.reg_wdata = d;
    cycle();
  endtask

  task automatic line(input int l);
    lb = 1'b1; fl = 11'(l);
    cycle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, a, k;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[9'h0A3] = 16'h8001;
    mem[9'h107] = 16'hC000;
    mem[9'h1F3] = 16'hFFFF;
    bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    lb = 1'b0; fl = '0; h = '0; on = 1'b0;
    model_reset();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    // Reset state: background everywhere, no fetches
    for (int i = 0; i < 40; i++) begin h = 12'(i * 32); on = 1'b1; cycle(); end
    chk("reset_bg", 32'({vr, vg, vb}), 32'(BG));

    // Sprite 0 basic fetch and draw
    wr(0, 16'd100); wr(1, 16'd50); wr(2, 16'h00A0); wr(3, 16'hF001);
    line(53);
    chk("s0_rd", 32'(bus.mem_rd), 32'd1);
    chk("s0_addr", 32'(bus.mem_addr), 32'h0A3);
    wait_idle();
    line(53);
    h = 12'd100; cycle(); chk("s0_h100", 32'({vr, vg, vb}), 32'hF00);
    h = 12'd115; cycle(); chk("s0_h115", 32'({vr, vg, vb}), 32'hF00);
    h = 12'd101; cycle(); chk("s0_h101", 32'({vr, vg, vb}), 32'(BG));
    h = 12'd116; cycle(); chk("s0_h116", 32'({vr, vg, vb}), 32'(BG));

    // Sprite 1 at scale 2
    wr(4, 16'd300); wr(5, 16'd50); wr(6, 16'h0100); wr(7, 16'h0F09);
    line(81);
    cycle();
    chk("s1_rd", 32'(bus.mem_rd), 32'd1);
    chk("s1_addr", 32'(bus.mem_addr), 32'h107);
    wait_idle();
    line(81);
    h = 12'd307; cycle(); chk("s1_h307", 32'({vr, vg, vb}), 32'h0F0);
    h = 12'd308; cycle(); chk("s1_h308", 32'({vr, vg, vb}), 32'(BG));
    wait_idle();
    line(114);
    cycle();
    chk("s1_out_rd", 32'(bus.mem_rd), 32'd0);

    // Collision between sprites 0 and 2
    wr(0, 16'd200); wr(8, 16'd200); wr(9, 16'd50); wr(10, 16'h00A0); wr(11, 16'h00F1);
    wait_idle(); line(53); wait_idle(); line(53);
    h = 12'd200; cycle();
    chk("ovl_color", 32'({vr, vg, vb}), 32'hF00);
    chk("ovl_flags", 32'(coll), 32'h05);
    bus.reg_wr = 1'b1; bus.reg_addr = 7'(4*N); bus.reg_wdata = 16'h1234; h = 12'd200; cycle();
    chk("clr_vs_set", 32'(coll), 32'h05);
    bus.reg_wr = 1'b1; bus.reg_addr = 7'(4*N); bus.reg_wdata = 16'h0000; h = 12'd201; cycle();
    chk("clr_alone", 32'(coll), 32'h00);

    // Overrun: all five in range, next linebegin six cycles later
    wr(12, 16'd400); wr(13, 16'd50); wr(14, 16'h00A0); wr(15, 16'h0FF1);
    wr(16, 16'd500); wr(17, 16'd50); wr(18, 16'h00A0); wr(19, 16'hFF01);
    wait_idle();
    line(53);
    repeat (5) cycle();
    line(53);
    chk("ovr_flag", 32'(ovr), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    h = 12'd400; cycle(); chk("ovr_s3_row0", 32'({vr, vg, vb}), 32'(BG));
    h = 12'd500; cycle(); chk("ovr_s4_row0", 32'({vr, vg, vb}), 32'(BG));

    // Y above the line: borrow, nothing fetched
    wait_idle();
    wr(5, 16'd1000);
    line(10);
    cnt = 0;
    for (int i = 0; i < 20 && ft != 0; i++) begin cnt += int'(bus.mem_rd); cycle(); end
    chk("borrow_no_rd", 32'(cnt), 32'd0);

    // Right edge without wrap
    wr(12, 16'd1270); wr(14, 16'h01F0);
    wait_idle(); line(53); wait_idle(); line(53);
    h = 12'd1270; cycle(); chk("edge_1270", 32'({vr, vg, vb}), 32'h0FF);
    h = 12'd1279; cycle(); chk("edge_1279", 32'({vr, vg, vb}), 32'h0FF);
    h = 12'd0;    cycle(); chk("edge_wrap0", 32'({vr, vg, vb}), 32'(BG));
    h = 12'd5;    cycle(); chk("edge_wrap5", 32'({vr, vg, vb}), 32'(BG));

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      h  = 12'($urandom_range(0, 420));
      on = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin lb = 1'b1; fl = 11'($urandom_range(30, 140)); end
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 127);
        k = a % 4;
        if (a >= 4*N || k == 0 || (ft == 0 && !lb)) begin
          bus.reg_wr = 1'b1; bus.reg_addr = 7'(a);
          case (k)
            0: bus.reg_wdata = 16'($urandom_range(0, 400));
            1: bus.reg_wdata = 16'($urandom_range(30, 140));
            default: bus.reg_wdata = 16'($urandom);
          endcase
        end
      end
      cycle();
    end

    // Reset in the middle of a WAIT cycle
    wait_idle();
    wr(1, 16'd50); wr(2, 16'h00A0); wr(3, 16'hF001);
    line(53);
    for (int i = 0; i < 20 && !(ft != 0 && s_st[ft] >= 0); i++) cycle();
    chk("pre_rst_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rgb", 32'({vr, vg, vb}), 32'h000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_coll", 32'(coll), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    h = 12'd200; on = 1'b1;
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised successor to the fixed per-sprite PongSprite/load_sprite_image pair.
- NUM_SPRITES 16x16 monochrome sprites, each with its own position, memory base, scale, 12-bit colour and enable.
- Prefetches one row per sprite from sprite memory during the current line, double-buffered, and composites by fixed priority to 4:4:4 RGB.
- Adds sticky per-sprite collision detection. Sits between cpu_vga_interface (register writes, sprite memory) and the VGA pins, in the pixel-clock domain.

Parameters:
- NUM_SPRITES, 5, number of sprite channels (1..16); index 0 has highest priority.
- MEM_AW, 9, sprite memory address width.
- REG_AW, 7, register address width; must satisfy 2^REG_AW > 4*NUM_SPRITES.
- BG_COLOR, 12'h000, {R,G,B} background colour on-screen.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- reg_wr  in  1  register write strobe, one cycle.
- reg_addr  in  REG_AW  register address.
- reg_wdata  in  16  register write data.
- linebegin  in  1  one-cycle pulse at start of each line.
- fetch_line  in  11  line number to prefetch; sampled on linebegin.
- h_addr  in  12  current pixel column.
- on_screen  in  1  active video.
- mem_rd  out  1  sprite memory read strobe.
- mem_addr  out  MEM_AW  sprite memory address.
- mem_rdata  in  16  read data; valid exactly 1 cycle after mem_rd.
- vga_r/vga_g/vga_b  out  4 each  registered pixel colour.
- coll_flags  out  NUM_SPRITES  sticky collision flags.
- fetch_busy  out  1  prefetch in progress.
- fetch_overrun  out  1  sticky: linebegin arrived before prefetch finished.

Behaviour:
- Reset: all sprite registers 0 (all disabled); pending and active rows 0; RGB 0; coll_flags 0; fetch_overrun 0; FSM IDLE; mem_rd 0.
- Register map, addr = 4*i + k:
  - k=0: X[11:0].
  - k=1: Y[10:0].
  - k=2: BASE[MEM_AW-1:0].
  - k=3: CTRL, with [15:4] colour {R,G,B}, [3:2] scale S (pixel size 2^S), [0] enable.
  - addr = 4*NUM_SPRITES: write of any data clears coll_flags.
  - Other addresses are ignored.
- Register writes take effect the next cycle. X/CTRL changes affect compositing immediately; Y/BASE changes affect the next prefetch only.
- On linebegin: copy pending rows into active rows, clear pending rows to 0, latch fetch_line, enter FETCH with i=0.
- FSM states:
  - IDLE.
  - CHECK: compute d = fetch_line - Y[i] (12-bit, borrow means out of range) and row = d >> S. In range iff no borrow and d < (16 << S). If in range and enabled: issue mem_rd=1, mem_addr=BASE+row (truncated to MEM_AW), go to WAIT. Otherwise leave pending row 0 and advance i.
  - WAIT: store mem_rdata into pending[i], advance i.
  - Advancing past NUM_SPRITES-1 returns to IDLE.
  - Worst case is 2*NUM_SPRITES cycles; fetch_busy=1 outside IDLE.
- linebegin during FETCH: commit pending as-is (unfetched rows are 0), set fetch_overrun, restart the fetch. linebegin wins over any same-cycle state step.
- Compositing, per sprite: c = h_addr - X (12-bit). Hit iff enabled, no borrow, c < (16 << S), and active[i][15 - (c >> S)] = 1. Bit 15 is the leftmost pixel.
- Output latency is 1 cycle (registered):
  - on_screen=0: RGB=0.
  - Otherwise: colour of the lowest-index hit, or BG_COLOR if no hit.
- Collision: if on_screen and two or more sprites hit in the same cycle, set coll_flags for every hitting sprite. A set in the same cycle as a clear write wins (flag ends 1).
- reset mid-line or mid-fetch: immediate return to reset state; no memory read is left outstanding.

Test Plan:
- Reset with reg_wr=0, h_addr sweep, on_screen=1 -> RGB=BG_COLOR every pixel; mem_rd never asserted; coll_flags=0.
- Sprite0: X=100, Y=50, BASE=0x0A0, CTRL=0xF001 (red, S=0); memory 0x0A3=0x8001; fetch_line=53 then linebegin -> mem_rd with mem_addr=0x0A3. After next linebegin: RGB=F00 at h=100 and h=115 (one cycle later), BG elsewhere.
- Sprite1: S=2, Y=50, fetch_line=50+4*7+3=81 -> mem_addr=BASE+7; each bit lit for 4 pixels. Sprite is 64 wide; fetch_line=114 -> no mem_rd, row 0.
- Sprites 0 and 2 overlap at h=200 -> colour of sprite 0; coll_flags=3'b101. Clear-write in the same cycle as a fresh overlap -> flags remain set. Clear-write with no overlap -> 0.
- NUM_SPRITES=5, all in range, linebegin 6 cycles after the previous one -> fetch_overrun=1; sprites 3-4 rows 0 next line; fetch restarts (fetch_busy=1).
- Y=1000, fetch_line=10 (borrow) -> no fetch. X=1270, S=0 -> pixels 1270..1279 drawn with no wrap to column 0. rst asserted mid-WAIT -> all outputs reset that cycle.
